// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Pipeline-to-hazard-controller bundle. Stage-register status
//                flows toward the controller. Stall, flush, forwarding and
//                redirect controls flow back to the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    // IF/ID view
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    // ID/EX view
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memRead;
    // EX/MEM view
    logic [4:0]  mem_rd;
    logic        mem_regWrite;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic        mem_branch;
    logic        mem_jump;
    logic        mem_jump_return;
    logic        mem_zero;
    logic        mem_lt_zero;
    logic [1:0]  mem_bType;
    logic [31:0] mem_branch_destination;
    logic [31:0] mem_ALU_result;
    // MEM/WB view
    logic [4:0]  wb_rd;
    logic        wb_regWrite;
    // data memory handshake
    logic        dmem_ready;
    // controls back into the pipeline
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        mem_wb_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;

    // Pipeline side: drives stage status, consumes controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_memRead,
        output mem_rd, mem_regWrite, mem_memRead, mem_memWrite,
        output mem_branch, mem_jump, mem_jump_return, mem_zero, mem_lt_zero,
        output mem_bType, mem_branch_destination, mem_ALU_result,
        output wb_rd, wb_regWrite, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  redirect, redirect_pc, forward_a, forward_b
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_memRead,
        input  mem_rd, mem_regWrite, mem_memRead, mem_memWrite,
        input  mem_branch, mem_jump, mem_jump_return, mem_zero, mem_lt_zero,
        input  mem_bType, mem_branch_destination, mem_ALU_result,
        input  wb_rd, wb_regWrite, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output redirect, redirect_pc, forward_a, forward_b
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Backward control for a 5-stage RISC-V pipeline. It handles
//                load-use stalls, taken branch/jump redirects resolved in MEM,
//                data-memory wait freeze and operand forwarding. It also keeps
//                saturating stall and flush counters and a sticky wait-timeout
//                flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 wait_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam int               c_WCNT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_MAX = WAIT_MAX[c_WCNT_W-1:0];

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  w_cond;
    logic                  w_taken;
    logic                  w_taken_eff;
    logic                  w_lu;
    logic                  w_mw;
    logic [31:0]           w_jalr_tgt;

    logic                  w_pc_write;
    logic                  w_if_id_write;
    logic                  w_id_ex_write;
    logic                  w_ex_mem_write;
    logic                  w_mem_wb_write;
    logic                  w_if_id_flush;
    logic                  w_id_ex_flush;
    logic                  w_ex_mem_flush;
    logic                  w_redirect;
    logic                  w_lu_stall;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic [c_WCNT_W-1:0]   r_wait_cnt;
    logic                  r_wait_err;

    logic [4:0]            w_ex_src [2];
    logic [1:0]            w_fwd    [2];

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // Branch condition selected by the branch type in EX/MEM
    always_comb begin
        w_cond = 1'b0;
        case (hz.mem_bType)
            2'b00:   w_cond =  hz.mem_zero;
            2'b01:   w_cond = ~hz.mem_zero;
            2'b10:   w_cond =  hz.mem_lt_zero;
            default: w_cond = ~hz.mem_lt_zero;
        endcase
    end

    assign w_taken     = hz.mem_jump | (hz.mem_branch & w_cond);
    // EX/MEM holds a squashed slot right after a redirect, so its taken is stale
    assign w_taken_eff = w_taken & (r_state != ST_FLUSH);

    assign w_lu = hz.ex_memRead && (hz.ex_rd != 5'd0) &&
                  ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    assign w_mw = (hz.mem_memRead | hz.mem_memWrite) & ~hz.dmem_ready;

    // jalr clears bit 0 of the computed target
    assign w_jalr_tgt = hz.mem_ALU_result & ~32'h0000_0001;

    assign hz.redirect_pc = hz.mem_jump_return ? w_jalr_tgt : hz.mem_branch_destination;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Prioritised control decode and next state: wait > redirect > load-use
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_mem_wb_write = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_redirect     = 1'b0;
        w_lu_stall     = 1'b0;
        w_next         = ST_RUN;
        if (w_mw) begin
            // freeze every stage until memory answers
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_write = 1'b0;
            w_next         = ST_WAIT;
        end else if (w_taken_eff) begin
            w_redirect     = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_next         = ST_FLUSH;
        end else if (w_lu) begin
            // hold the consumer in ID, insert a bubble behind the load
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_lu_stall     = 1'b1;
            w_next         = ST_STALL;
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.id_ex_write  = w_id_ex_write;
    assign hz.ex_mem_write = w_ex_mem_write;
    assign hz.mem_wb_write = w_mem_wb_write;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.ex_mem_flush = w_ex_mem_flush;
    assign hz.redirect     = w_redirect;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    // Saturating counts of load-use stall cycles and redirect cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // ------------------------------------------------------------------
    // Memory wait watchdog
    // ------------------------------------------------------------------
    // r_wait_cnt holds the number of completed wait cycles before the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_wait_err <= 1'b0;
        end else if (w_mw) begin
            if (r_state != ST_WAIT) begin
                r_wait_cnt <= c_WCNT_W'(1);
            end else begin
                if (r_wait_cnt != c_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + c_WCNT_W'(1);
                end
                if (r_wait_cnt >= c_WAIT_MAX) begin
                    r_wait_err <= 1'b1;
                end
            end
        end
    end

    assign wait_err = r_wait_err;

    // ------------------------------------------------------------------
    // Forwarding (independent of FSM state)
    // ------------------------------------------------------------------
    assign w_ex_src[0] = hz.ex_rs1;
    assign w_ex_src[1] = hz.ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // EX/MEM result is younger than MEM/WB data, so it wins
            assign w_fwd[gi] =
                (hz.mem_regWrite && (hz.mem_rd != 5'd0) && (hz.mem_rd == w_ex_src[gi])) ? 2'b10 :
                (hz.wb_regWrite  && (hz.wb_rd  != 5'd0) && (hz.wb_rd  == w_ex_src[gi])) ? 2'b01 :
                                                                                         2'b00;
        end
    endgenerate

    assign hz.forward_a = w_fwd[0];
    assign hz.forward_b = w_fwd[1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. Expected control
//                words are queued as stimulus is applied and popped when the
//                DUT outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W    = 16;
    localparam int WAIT_MAX = 255;

    // wr = {pc, if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, ex_mem}
    typedef struct packed {
        logic [4:0]  wr;
        logic [2:0]  fl;
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             wait_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .wait_err  (wait_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] wr, input logic [2:0] fl, input logic r,
                                input logic [31:0] pc, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.wr = wr; e.fl = fl; e.redir = r; e.rpc = pc; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    task automatic quiet();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rd = 5'd0; bus.ex_memRead = 1'b0;
        bus.mem_rd = 5'd0; bus.mem_regWrite = 1'b0; bus.mem_memRead = 1'b0; bus.mem_memWrite = 1'b0;
        bus.mem_branch = 1'b0; bus.mem_jump = 1'b0; bus.mem_jump_return = 1'b0;
        bus.mem_zero = 1'b0; bus.mem_lt_zero = 1'b0; bus.mem_bType = 2'b00;
        bus.mem_branch_destination = 32'h0; bus.mem_ALU_result = 32'h0;
        bus.wb_rd = 5'd0; bus.wb_regWrite = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    task automatic set_lu();
        bus.ex_memRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        quiet();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pops the oldest expectation and captures the DUT outputs away from the edge
    task automatic sample(output exp_t obs, output exp_t e);
        #2;
        obs.wr    = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write, bus.mem_wb_write};
        obs.fl    = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
        obs.redir = bus.redirect;
        obs.rpc   = bus.redirect_pc;
        obs.fa    = bus.forward_a;
        obs.fb    = bus.forward_b;
        if (sb.size() == 0) e = 'x;
        else                e = sb.pop_front();
    endtask

    localparam logic [4:0] W_ALL = 5'b11111;
    localparam logic [4:0] W_LU  = 5'b00111;
    localparam logic [4:0] W_NONE = 5'b00000;

    task automatic test_reset();
        exp_t o, e;
        @(negedge clk);
        rst_n = 1'b0;
        quiet();
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", o, e); end
        n_chk++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || wait_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b want 0 0 0", stall_cnt, flush_cnt, wait_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL idle_ctrl: got %h want %h", o, e); end
    endtask

    task automatic test_load_use();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        set_lu();
        sb.push_back(mk(W_LU, 3'b010, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL lu_stall: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL lu_release: got %h want %h", o, e); end
        n_chk++;
        if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL lu_counters: got stall=%0d flush=%0d want 1 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        set_lu();
        sb.push_back(mk(W_LU, 3'b010, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_first: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        bus.ex_memRead = 1'b1; bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9; bus.id_use_rs2 = 1'b1;
        sb.push_back(mk(W_LU, 3'b010, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_second_rs2: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        bus.ex_memRead = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL lu_x0_ignored: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        bus.ex_memRead = 1'b1; bus.ex_rd = 5'd4; bus.id_rs1 = 5'd4; bus.id_use_rs1 = 1'b0;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL lu_unused_src: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        #2;
        n_chk++;
        if (stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_stall_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_branch();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        set_lu();
        bus.mem_branch = 1'b1; bus.mem_bType = 2'b01; bus.mem_zero = 1'b0;
        bus.mem_branch_destination = 32'h40;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h40, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL bne_taken: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL bne_after: got %h want %h", o, e); end
        n_chk++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL bne_counters: got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
        end
        @(negedge clk);
        bus.mem_branch = 1'b1; bus.mem_bType = 2'b00; bus.mem_zero = 1'b0;
        bus.mem_branch_destination = 32'h44;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h44, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL beq_not_taken: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_bType = 2'b10; bus.mem_lt_zero = 1'b1; bus.mem_branch_destination = 32'h48;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h48, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL blt_taken: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_bType = 2'b11;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h48, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL bge_not_taken: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_lt_zero = 1'b0;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h48, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL bge_taken: got %h want %h", o, e); end
    endtask

    task automatic test_jalr();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        bus.mem_jump = 1'b1; bus.mem_jump_return = 1'b1;
        bus.mem_ALU_result = 32'h1003; bus.mem_branch_destination = 32'h500;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h1002, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL jalr_redirect: got %h want %h", o, e); end
        @(negedge clk);
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h1002, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL jalr_flush_ignored: got %h want %h", o, e); end
        @(negedge clk);
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h1002, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL jalr_again: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        @(negedge clk);
        bus.mem_jump = 1'b1; bus.mem_branch_destination = 32'h500; bus.mem_ALU_result = 32'h1003;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h500, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL jal_redirect: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        #2;
        n_chk++;
        if (flush_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL jalr_flush_cnt: got %0d want 3", flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        exp_t o, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_lu();
            bus.mem_memRead = 1'b1; bus.dmem_ready = 1'b0;
            bus.mem_branch = 1'b1; bus.mem_bType = 2'b00; bus.mem_zero = 1'b1;
            bus.mem_branch_destination = 32'h80;
            sb.push_back(mk(W_NONE, 3'b000, 1'b0, 32'h80, 2'b00, 2'b00));
            sample(o, e);
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL mw_freeze_%0d: got %h want %h", i, o, e); end
        end
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        sb.push_back(mk(W_ALL, 3'b111, 1'b1, 32'h80, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL mw_release_redirect: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        #2;
        n_chk++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0 || wait_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mw_counters: got flush=%0d stall=%0d err=%b want 1 0 0", flush_cnt, stall_cnt, wait_err);
        end
    endtask

    task automatic test_forwarding();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd3;
        bus.mem_regWrite = 1'b1; bus.wb_regWrite = 1'b1;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b10, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_mem_priority: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_rd = 5'd0; bus.ex_rs2 = 5'd7;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b01, 2'b01));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_wb_rd0: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_rd = 5'd7; bus.wb_regWrite = 1'b0;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b10, 2'b10));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_mem_both: got %h want %h", o, e); end
        @(negedge clk);
        bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0;
        bus.wb_regWrite = 1'b1;
        sb.push_back(mk(W_ALL, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_x0: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        bus.mem_memWrite = 1'b1; bus.dmem_ready = 1'b0;
        bus.mem_rd = 5'd9; bus.mem_regWrite = 1'b1; bus.ex_rs1 = 5'd9;
        sb.push_back(mk(W_NONE, 3'b000, 1'b0, 32'h0, 2'b10, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_during_wait: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_wait_err();
        exp_t o, e;
        do_reset();
        @(negedge clk);
        bus.mem_memWrite = 1'b1; bus.dmem_ready = 1'b0;
        repeat (WAIT_MAX) @(posedge clk);
        #1;
        n_chk++;
        if (wait_err !== 1'b0) begin n_fail++; $display("FAIL wait_err_early: got %b want 0", wait_err); end
        @(posedge clk);
        #1;
        n_chk++;
        if (wait_err !== 1'b1) begin n_fail++; $display("FAIL wait_err_set: got %b want 1", wait_err); end
        @(negedge clk);
        sb.push_back(mk(W_NONE, 3'b000, 1'b0, 32'h0, 2'b00, 2'b00));
        sample(o, e);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL wait_err_still_frozen: got %h want %h", o, e); end
        @(negedge clk);
        quiet();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (wait_err !== 1'b1) begin n_fail++; $display("FAIL wait_err_sticky: got %b want 1", wait_err); end
        do_reset();
        #2;
        n_chk++;
        if (wait_err !== 1'b0) begin n_fail++; $display("FAIL wait_err_reset: got %b want 0", wait_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_jalr();
        test_mem_wait();
        test_forwarding();
        test_wait_err();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
